// File: rtl/lr35902_block_dma_if.sv
// Register-bus and memory-bus signals of the block DMA engine.
// slave = the DMA engine, master = CPU register port plus memory arbiter.
`timescale 1ns/1ps
interface lr35902_block_dma_if #(
    parameter int ADR_WIDTH = 16
);
    logic [2:0]           reg_adr;
    logic [7:0]           reg_din;
    logic                 reg_write;
    logic [7:0]           reg_dout;
    logic [ADR_WIDTH-1:0] adr_src;
    logic [7:0]           din;
    logic                 read;
    logic [ADR_WIDTH-1:0] adr_dst;
    logic [7:0]           dout;
    logic                 write;

    modport slave (
        input  reg_adr, reg_din, reg_write, din,
        output reg_dout, adr_src, read, adr_dst, dout, write
    );

    modport master (
        output reg_adr, reg_din, reg_write, din,
        input  reg_dout, adr_src, read, adr_dst, dout, write
    );
endinterface

// File: rtl/lr35902_block_dma.sv
// Block copy engine: moves BLOCK_BYTES-sized blocks, either back-to-back
// (general mode) or one block per hblank period, halting the CPU while copying.
`timescale 1ns/1ps
module lr35902_block_dma #(
    parameter int ADR_WIDTH       = 16,
    parameter int BLOCK_BYTES     = 16,
    parameter int CYCLES_PER_BYTE = 4,
    parameter int START_DELAY     = 8
) (
    input  logic               clk,
    input  logic               reset,
    lr35902_block_dma_if.slave bus,
    input  logic               hblank,
    output logic               active,
    output logic               cpu_halt
);
    localparam int BW = $clog2(BLOCK_BYTES);
    localparam int CW = $clog2(CYCLES_PER_BYTE);
    localparam int DW = $clog2(START_DELAY + 2);
    localparam logic [ADR_WIDTH-1:0] ALIGN_MASK = ~ADR_WIDTH'(BLOCK_BYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_BUSY} state_t;

    state_t               state_q, state_d;
    logic [DW-1:0]        delay_q, delay_d;
    logic [CW-1:0]        cycle_q, cycle_d;
    logic [BW-1:0]        byte_q, byte_d;
    logic [6:0]           rem_q, rem_d;
    logic                 mode_q, mode_d;
    logic                 armed_q, armed_d;
    logic                 cancel_q, cancel_d;
    logic [7:0]           src_hi_q, src_hi_d, src_lo_q, src_lo_d;
    logic [7:0]           dst_hi_q, dst_hi_d, dst_lo_q, dst_lo_d;
    logic [ADR_WIDTH-1:0] adr_src_q, adr_src_d, adr_dst_q, adr_dst_d;
    logic                 rw_q, rw_d;
    logic                 active_q, active_d;
    logic                 halt_q, halt_d;
    logic                 wr_ctrl, cancel_req;

    always_comb begin
        state_d   = state_q;
        delay_d   = delay_q;
        cycle_d   = cycle_q;
        byte_d    = byte_q;
        rem_d     = rem_q;
        mode_d    = mode_q;
        armed_d   = armed_q;
        cancel_d  = cancel_q;
        src_hi_d  = src_hi_q;
        src_lo_d  = src_lo_q;
        dst_hi_d  = dst_hi_q;
        dst_lo_d  = dst_lo_q;
        adr_src_d = adr_src_q;
        adr_dst_d = adr_dst_q;

        wr_ctrl    = bus.reg_write && (bus.reg_adr == 3'd4);
        cancel_req = wr_ctrl && active_q && mode_q && !bus.reg_din[7];

        if (!hblank) armed_d = 1'b1;

        if (bus.reg_write) begin
            case (bus.reg_adr)
                3'd0:    src_hi_d = bus.reg_din;
                3'd1:    src_lo_d = bus.reg_din;
                3'd2:    dst_hi_d = bus.reg_din;
                3'd3:    dst_lo_d = bus.reg_din;
                default: ;
            endcase
        end

        case (state_q)
            S_START: begin
                if (delay_q == DW'(START_DELAY)) begin
                    state_d = mode_q ? S_WAIT : S_BUSY;
                    cycle_d = '0;
                    byte_d  = '0;
                end else begin
                    delay_d = delay_q + DW'(1);
                end
            end
            S_WAIT: begin
                if (hblank && armed_q) begin
                    state_d = S_BUSY;
                    armed_d = 1'b0;
                end
            end
            S_BUSY: begin
                if (cycle_q == CW'(CYCLES_PER_BYTE - 1)) begin
                    cycle_d   = '0;
                    byte_d    = byte_q + BW'(1);
                    adr_src_d = adr_src_q + ADR_WIDTH'(1);
                    adr_dst_d = adr_dst_q + ADR_WIDTH'(1);
                    if (byte_q == BW'(BLOCK_BYTES - 1)) begin
                        // rem wraps 0 -> 0x7F on the final block, which reads back as "done"
                        rem_d = rem_q - 7'd1;
                        if (rem_q == 7'd0 || cancel_q) state_d = S_IDLE;
                        else                           state_d = mode_q ? S_WAIT : S_BUSY;
                    end
                end else begin
                    cycle_d = cycle_q + CW'(1);
                end
            end
            default: ;
        endcase

        // A hblank-mode cancel lets a block already in flight run to completion.
        if (cancel_req) begin
            if (state_q == S_BUSY && state_d == S_BUSY) cancel_d = 1'b1;
            else                                        state_d  = S_IDLE;
        end else if (wr_ctrl) begin
            state_d   = S_START;
            delay_d   = '0;
            mode_d    = bus.reg_din[7];
            rem_d     = bus.reg_din[6:0];
            armed_d   = 1'b1;
            cancel_d  = 1'b0;
            adr_src_d = ADR_WIDTH'({src_hi_q, src_lo_q}) & ALIGN_MASK;
            adr_dst_d = ADR_WIDTH'({dst_hi_q, dst_lo_q}) & ALIGN_MASK;
        end

        if (state_d == S_IDLE) cancel_d = 1'b0;

        rw_d     = (state_d == S_BUSY) && (cycle_d < CW'(CYCLES_PER_BYTE / 2));
        active_d = (state_d != S_IDLE);
        halt_d   = (state_d == S_BUSY);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            delay_q   <= '0;
            cycle_q   <= '0;
            byte_q    <= '0;
            rem_q     <= 7'h7F;
            mode_q    <= 1'b0;
            armed_q   <= 1'b1;
            cancel_q  <= 1'b0;
            src_hi_q  <= '0;
            src_lo_q  <= '0;
            dst_hi_q  <= '0;
            dst_lo_q  <= '0;
            adr_src_q <= '0;
            adr_dst_q <= '0;
            rw_q      <= 1'b0;
            active_q  <= 1'b0;
            halt_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            delay_q   <= delay_d;
            cycle_q   <= cycle_d;
            byte_q    <= byte_d;
            rem_q     <= rem_d;
            mode_q    <= mode_d;
            armed_q   <= armed_d;
            cancel_q  <= cancel_d;
            src_hi_q  <= src_hi_d;
            src_lo_q  <= src_lo_d;
            dst_hi_q  <= dst_hi_d;
            dst_lo_q  <= dst_lo_d;
            adr_src_q <= adr_src_d;
            adr_dst_q <= adr_dst_d;
            rw_q      <= rw_d;
            active_q  <= active_d;
            halt_q    <= halt_d;
        end
    end

    assign bus.adr_src  = adr_src_q;
    assign bus.adr_dst  = adr_dst_q;
    assign bus.read     = rw_q;
    assign bus.write    = rw_q;
    assign bus.dout     = bus.din;
    assign bus.reg_dout = {~active_q, rem_q};
    assign active       = active_q;
    assign cpu_halt     = halt_q;
endmodule

// File: tb/tb_lr35902_block_dma.sv
// Directed bench for lr35902_block_dma: table of general-mode transfers plus
// hand-written hblank, cancel and asynchronous-reset sequences.
`timescale 1ns/1ps
module tb_lr35902_block_dma;
    logic clk = 1'b0;
    logic rst_n;
    logic hblank;
    logic active;
    logic cpu_halt;
    int   checks   = 0;
    int   failures = 0;

    lr35902_block_dma_if #(.ADR_WIDTH(16)) dbus();

    lr35902_block_dma #(
        .ADR_WIDTH(16), .BLOCK_BYTES(16), .CYCLES_PER_BYTE(4), .START_DELAY(8)
    ) dut (
        .clk(clk), .reset(rst_n), .bus(dbus), .hblank(hblank),
        .active(active), .cpu_halt(cpu_halt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    always_comb dbus.din = mem_byte(dbus.adr_src);

    typedef struct {
        logic [15:0] src;
        logic [15:0] dst;
        logic [7:0]  ctrl;
        logic [15:0] s0;
        logic [15:0] d0;
        int          nbytes;
        logic [7:0]  status;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic reg_wr(input logic [2:0] adr, input logic [7:0] data);
        dbus.reg_adr   = adr;
        dbus.reg_din   = data;
        dbus.reg_write = 1'b1;
        @(negedge clk);
        dbus.reg_write = 1'b0;
        $display("reg_wr adr=%0d data=0x%02h", adr, data);
    endtask

    task automatic set_regs(input logic [15:0] src, input logic [15:0] dst);
        reg_wr(3'd0, src[15:8]);
        reg_wr(3'd1, src[7:0]);
        reg_wr(3'd2, dst[15:8]);
        reg_wr(3'd3, dst[7:0]);
    endtask

    // Steps negedges until read is seen; n = negedges waited.
    task automatic wait_read(input int budget, output int n);
        n = 0;
        while (n < budget && dbus.read !== 1'b1) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic count_reads(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (dbus.read === 1'b1 || dbus.write === 1'b1) cnt++;
        end
    endtask

    // Starting on the first read cycle, checks n consecutive bytes: strobes
    // high for 2 of 4 cycles, halt held, addresses and data incrementing.
    task automatic expect_bytes(input string tag, input int n, input logic [15:0] s0,
                                input logic [15:0] d0, input int inj_byte, input logic [7:0] inj_val);
        int bad = 0;
        logic [15:0] s, d;
        logic rw_exp;
        for (int i = 0; i < n; i++) begin
            s = s0 + 16'(i);
            d = d0 + 16'(i);
            for (int c = 0; c < 4; c++) begin
                rw_exp = (c < 2);
                if (dbus.read !== rw_exp || dbus.write !== rw_exp || cpu_halt !== 1'b1) bad++;
                if (c == 0 && (dbus.adr_src !== s || dbus.adr_dst !== d || dbus.dout !== mem_byte(s))) bad++;
                if (i == inj_byte && c == 0) begin
                    dbus.reg_adr   = 3'd4;
                    dbus.reg_din   = inj_val;
                    dbus.reg_write = 1'b1;
                end
                if (i == inj_byte && c == 1) dbus.reg_write = 1'b0;
                @(negedge clk);
            end
        end
        $display("xfer %s bytes=%0d src=0x%04h dst=0x%04h bad=%0d", tag, n, s0, d0, bad);
        chk(tag, bad, 0);
    endtask

    initial begin
        int n;
        int cnt;
        vec_t v;
        logic [7:0] hb_status [3];

        vecs[0] = '{16'hC123, 16'h8005, 8'h01, 16'hC120, 16'h8000, 32, 8'h01};
        vecs[1] = '{16'hFFF0, 16'hFFF0, 8'h01, 16'hFFF0, 16'hFFF0, 32, 8'h01};
        vecs[2] = '{16'h1234, 16'hABCD, 8'h00, 16'h1230, 16'hABC0, 16, 8'h00};
        vecs[3] = '{16'h7FFF, 16'h0007, 8'h02, 16'h7FF0, 16'h0000, 48, 8'h02};
        hb_status[0] = 8'h01;
        hb_status[1] = 8'h00;
        hb_status[2] = 8'hFF;

        rst_n          = 1'b0;
        hblank         = 1'b0;
        dbus.reg_adr   = 3'd0;
        dbus.reg_din   = 8'h00;
        dbus.reg_write = 1'b0;
        @(negedge clk);
        chk("rst_reg_dout", dbus.reg_dout, 8'hFF);
        chk("rst_active", active, 1'b0);
        chk("rst_read", dbus.read, 1'b0);
        chk("rst_adr_src", dbus.adr_src, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        // General-mode table
        for (int i = 0; i < 4; i++) begin
            v = vecs[i];
            set_regs(v.src, v.dst);
            reg_wr(3'd4, v.ctrl);
            chk($sformatf("v%0d_status", i), dbus.reg_dout, v.status);
            chk($sformatf("v%0d_halt_in_start", i), cpu_halt, 1'b0);
            wait_read(40, n);
            chk($sformatf("v%0d_latency", i), n, 9);
            expect_bytes($sformatf("v%0d_bytes", i), v.nbytes, v.s0, v.d0, -1, 8'h00);
            chk($sformatf("v%0d_active_end", i), active, 1'b0);
            chk($sformatf("v%0d_status_end", i), dbus.reg_dout, 8'hFF);
        end

        // Hblank mode, three pulses
        set_regs(16'h4000, 16'h9000);
        reg_wr(3'd4, 8'h82);
        count_reads(20, cnt);
        chk("hb_no_read_wait", cnt, 0);
        chk("hb_active_wait", active, 1'b1);
        chk("hb_halt_wait", cpu_halt, 1'b0);
        chk("hb_status_wait", dbus.reg_dout, 8'h02);
        for (int k = 0; k < 3; k++) begin
            hblank = 1'b1;
            wait_read(5, n);
            chk($sformatf("hb%0d_trig_latency", k), n, 1);
            hblank = 1'b0;
            expect_bytes($sformatf("hb%0d_bytes", k), 16, 16'h4000 + 16'(16 * k),
                         16'h9000 + 16'(16 * k), -1, 8'h00);
            chk($sformatf("hb%0d_status", k), dbus.reg_dout, hb_status[k]);
            count_reads(6, cnt);
        end
        chk("hb_active_end", active, 1'b0);

        // Hblank already high at start; held high blocks the second block
        hblank = 1'b1;
        reg_wr(3'd4, 8'h81);
        wait_read(30, n);
        chk("hbh_latency", n, 10);
        expect_bytes("hbh_blk0", 16, 16'h4000, 16'h9000, -1, 8'h00);
        count_reads(30, cnt);
        chk("hbh_held_no_read", cnt, 0);
        chk("hbh_status", dbus.reg_dout, 8'h00);
        hblank = 1'b0;
        @(negedge clk);
        hblank = 1'b1;
        wait_read(5, n);
        chk("hbh_retrig", n, 1);
        expect_bytes("hbh_blk1", 16, 16'h4010, 16'h9010, -1, 8'h00);
        chk("hbh_active_end", active, 1'b0);
        hblank = 1'b0;

        // Cancel while waiting for hblank
        reg_wr(3'd4, 8'h82);
        count_reads(12, cnt);
        hblank = 1'b1;
        wait_read(5, n);
        hblank = 1'b0;
        expect_bytes("cw_blk0", 16, 16'h4000, 16'h9000, -1, 8'h00);
        reg_wr(3'd4, 8'h00);
        chk("cw_active", active, 1'b0);
        chk("cw_status", dbus.reg_dout, 8'h81);
        hblank = 1'b1;
        count_reads(20, cnt);
        chk("cw_no_read", cnt, 0);
        hblank = 1'b0;

        // Cancel while a block is moving: block completes, then idle
        reg_wr(3'd4, 8'h82);
        count_reads(12, cnt);
        hblank = 1'b1;
        wait_read(5, n);
        hblank = 1'b0;
        expect_bytes("cb_blk0", 16, 16'h4000, 16'h9000, 5, 8'h00);
        chk("cb_active", active, 1'b0);
        hblank = 1'b1;
        count_reads(20, cnt);
        chk("cb_no_read", cnt, 0);
        hblank = 1'b0;

        // Asynchronous reset mid-block
        reg_wr(3'd4, 8'h00);
        wait_read(20, n);
        expect_bytes("rs_pre", 5, 16'h4000, 16'h9000, -1, 8'h00);
        #1 rst_n = 1'b0;
        #1;
        chk("rs_read", dbus.read, 1'b0);
        chk("rs_write", dbus.write, 1'b0);
        chk("rs_active", active, 1'b0);
        chk("rs_halt", cpu_halt, 1'b0);
        chk("rs_adr_src", dbus.adr_src, 16'h0000);
        chk("rs_adr_dst", dbus.adr_dst, 16'h0000);
        chk("rs_reg_dout", dbus.reg_dout, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        count_reads(30, cnt);
        chk("rs_no_read_after", cnt, 0);
        reg_wr(3'd4, 8'h00);
        wait_read(40, n);
        chk("rs_new_latency", n, 9);
        expect_bytes("rs_regs_cleared", 16, 16'h0000, 16'h0000, -1, 8'h00);
        chk("rs_active_end", active, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
